frm_arbiter: RTL and testbench

Round-robin scheduler that shares the single two-byte UART frame transmitter (the `snd_frm`/`frm_cmplt` frame control path) between up to `NUM_REQ` requesters. It latches one 16-bit frame per requester, picks the next pending requester fairly, launches the frame, and waits for completion. A per-requester `done` pulse is returned when the frame has been sent. It sits between the telemetry/command sources and the frame transmitter.

---
 rtl/frm_arbiter.sv | 132 +++++++++++++
 tb/tb_frm_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frm_arbiter.sv
// Round-robin scheduler sharing one two-byte frame transmitter between NUM_REQ requesters.
// Optional WAIT-state abort enabled by defining TX_TIMEOUT_EN.
module frm_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [16*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         pending,
    output logic [15:0]                frm_data,
    output logic                       snd_frm,
    input  logic                       frm_cmplt,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic                       timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [15:0]       hold [NUM_REQ];
    logic              cmplt_q;
    logic              rise;
    logic              finish;
    logic              expire;
    logic [NUM_REQ-1:0] cur_sel;
    logic [NUM_REQ-1:0] clr_mask;
    logic              win_found;
    logic [ID_W-1:0]   win_id;

    assign snd_frm  = (state == S_LAUNCH);
    assign busy     = (state != S_IDLE);
    assign rise     = frm_cmplt & ~cmplt_q;
    assign finish   = (state == S_WAIT) & rise;
    assign cur_sel  = NUM_REQ'(1) << cur_id;
    assign clr_mask = (finish | expire) ? cur_sel : '0;

    // Walk from last_id+k downwards in k so the smallest offset ends up as the winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (pending[ID_W'((int'(last_id) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(last_id) + k) % NUM_REQ);
            end
        end
    end

    // A new request landing on the clear cycle re-arms the slot with fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_REQ; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (!pending[i] || clr_mask[i])) begin
                    pending[i] <= 1'b1;
                    hold[i]    <= req_data[16*i +: 16];
                end else if (clr_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur_id   <= '0;
            frm_data <= '0;
            last_id  <= ID_W'(NUM_REQ - 1);
            done     <= '0;
            cmplt_q  <= 1'b1;
        end else begin
            cmplt_q <= frm_cmplt;
            done    <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur_id   <= win_id;
                        frm_data <= hold[win_id];
                        last_id  <= win_id;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    if (finish) begin
                        done  <= cur_sel;
                        state <= S_IDLE;
                    end else if (expire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Completion seen on the expiry cycle wins over the abort.
    assign expire = (state == S_WAIT) && !rise && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
            if (state == S_LAUNCH) wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign expire      = 1'b0 & (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frm_arbiter.sv
// Scoreboard bench for frm_arbiter: expected launches/done pulses queued by stimulus, popped by a monitor.
module tb_frm_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   pending;
    logic [15:0]          frm_data;
    logic                 snd_frm;
    logic                 frm_cmplt;
    logic                 busy;
    logic [ID_W-1:0]      cur_id;
    logic                 timeout_err;

    int checks = 0;
    int errors = 0;

    logic [17:0]        exp_launch_q[$];
    logic [NUM_REQ-1:0] exp_done_q[$];

    int   tx_cnt;
    logic tx_active;
    logic tx_hang;
    int   tx_delay;

    always #5 clk = ~clk;

    frm_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .done        (done),
        .pending     (pending),
        .frm_data    (frm_data),
        .snd_frm     (snd_frm),
        .frm_cmplt   (frm_cmplt),
        .busy        (busy),
        .cur_id      (cur_id),
        .timeout_err (timeout_err)
    );

    // Transmitter model: drops frm_cmplt after snd_frm, raises it tx_delay cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cmplt <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= 0;
        end else if (snd_frm) begin
            frm_cmplt <= 1'b0;
            tx_active <= 1'b1;
            tx_cnt    <= tx_delay;
        end else if (tx_active && !tx_hang) begin
            if (tx_cnt <= 1) begin
                frm_cmplt <= 1'b1;
                tx_active <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: compares every launch and every done pulse against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (snd_frm) begin
                if (exp_launch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL launch_extra: id %0d data 0x%0h with nothing expected", cur_id, frm_data);
                end else begin
                    check("launch_id_data", {14'b0, cur_id, frm_data}, {14'b0, exp_launch_q.pop_front()});
                end
                check("launch_busy", busy, 1);
            end
            if (done != '0) begin
                check("done_onehot", $onehot(done), 1);
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_extra: done 0x%0h with nothing expected", done);
                end else begin
                    check("done_id", done, exp_done_q.pop_front());
                end
            end
`ifndef TX_TIMEOUT_EN
            if (timeout_err) begin
                checks++;
                errors++;
                $display("FAIL timeout_err_tied: got 1 expected 0");
            end
`endif
        end
    end

    task automatic issue(input logic [NUM_REQ-1:0] mask, input logic [16*NUM_REQ-1:0] data);
        @(posedge clk);
        #1;
        req      = mask;
        req_data = data;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || pending != '0) && n < max);
        if (busy || pending != '0) fail_now("wait_idle");
    endtask

    task automatic req_on_done(input int id, input logic [15:0] data);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[id] && n < 2000);
        if (!done[id]) fail_now("req_on_done");
        req               = '0;
        req[id]           = 1'b1;
        req_data          = '0;
        req_data[16*id +: 16] = data;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_snd_frm"},     snd_frm,     0);
        check({tag, "_frm_data"},    frm_data,    0);
        check({tag, "_done"},        done,        0);
        check({tag, "_pending"},     pending,     0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_cur_id"},      cur_id,      0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        tx_hang  = 1'b0;
        tx_delay = 10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four at once from reset: served 0,1,2,3.
        exp_launch_q.push_back({2'd0, 16'h1111});
        exp_launch_q.push_back({2'd1, 16'h2222});
        exp_launch_q.push_back({2'd2, 16'h3333});
        exp_launch_q.push_back({2'd3, 16'h4444});
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0100);
        exp_done_q.push_back(4'b1000);
        issue(4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        @(negedge clk);
        check("all4_pending", pending, 4'b1111);
        wait_idle(500);

        // Fairness: last_id=3, so 0 first; 0 re-requests on its done while 3 waits one frame.
        exp_launch_q.push_back({2'd0, 16'h0A01});
        exp_launch_q.push_back({2'd3, 16'h3A00});
        exp_launch_q.push_back({2'd0, 16'h0A02});
        exp_launch_q.push_back({2'd0, 16'h0A03});
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b1000);
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0001);
        issue(4'b1001, {16'h3A00, 16'h0000, 16'h0000, 16'h0A01});
        req_on_done(0, 16'h0A02);
        req_on_done(0, 16'h0A03);
        wait_idle(500);

        // Single request with 40-cycle transmitter.
        tx_delay = 40;
        exp_launch_q.push_back({2'd2, 16'hA55A});
        exp_done_q.push_back(4'b0100);
        issue(4'b0100, {16'h0000, 16'hA55A, 16'h0000, 16'h0000});
        @(negedge clk);
        check("single_pending", pending, 4'b0100);
        check("single_no_snd_yet", snd_frm, 0);
        @(negedge clk);
        check("single_snd", snd_frm, 1);
        check("single_cur_id", cur_id, 2);
        check("single_frm_data", frm_data, 16'hA55A);
        @(negedge clk);
        check("single_wait_snd", snd_frm, 0);
        check("single_wait_busy", busy, 1);
        check("single_wait_data", frm_data, 16'hA55A);
        wait_idle(500);
        check("single_pending_clear", pending, 0);
        tx_delay = 10;

        // Request while pending is dropped; request on the clear cycle wins.
        exp_launch_q.push_back({2'd1, 16'hBEEF});
        exp_done_q.push_back(4'b0010);
        issue(4'b0010, {16'h0000, 16'h0000, 16'hBEEF, 16'h0000});
        issue(4'b0010, {16'h0000, 16'h0000, 16'hDEAD, 16'h0000});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !snd_frm && frm_cmplt) && n < 500);
        if (!(busy && !snd_frm && frm_cmplt)) fail_now("rise_wait");
        exp_launch_q.push_back({2'd1, 16'hCAFE});
        exp_done_q.push_back(4'b0010);
        req      = 4'b0010;
        req_data = {16'h0000, 16'h0000, 16'hCAFE, 16'h0000};
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        check("set_wins_pending", pending, 4'b0010);
        check("set_wins_done", done, 4'b0010);
        wait_idle(500);

        // Reset in the middle of WAIT.
        tx_hang = 1'b1;
        exp_launch_q.push_back({2'd2, 16'h5555});
        issue(4'b0100, {16'h0000, 16'h5555, 16'h0000, 16'h0000});
        repeat (5) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tx_hang = 1'b0;
        // last_id back to 3, so requester 0 precedes 3.
        exp_launch_q.push_back({2'd0, 16'h7070});
        exp_launch_q.push_back({2'd3, 16'h7373});
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b1000);
        issue(4'b1001, {16'h7373, 16'h0000, 16'h0000, 16'h7070});
        wait_idle(500);

`ifdef TX_TIMEOUT_EN
        tx_hang = 1'b1;
        exp_launch_q.push_back({2'd0, 16'h0B0B});
        exp_launch_q.push_back({2'd1, 16'h1B1B});
        exp_done_q.push_back(4'b0010);
        issue(4'b0011, {16'h0000, 16'h0000, 16'h1B1B, 16'h0B0B});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !snd_frm) && n < 50);
        n = 0;
        while (!timeout_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 100);
        check("timeout_no_done", done, 0);
        check("timeout_pending", pending, 4'b0010);
        tx_hang = 1'b0;
        wait_idle(500);
`endif

        repeat (5) @(negedge clk);
        check("launch_queue_empty", exp_launch_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
